// File: rtl/ring_link_tx_pkg.sv
// Shared definitions for the ring-router link transmitter and its credit logic.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package ring_link_tx_pkg;

  localparam int DEF_NUM_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } tx_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_link_tx_credit_counter.sv
// Up/down credit counter starting full at MAX, with a sticky overflow flag.
// Latency: count reflects inc/dec one cycle after they are sampled.
// Backpressure: none; dec at zero and inc at MAX are ignored (inc at MAX flags err).
module ring_credit_counter
  import ring_link_tx_pkg::*;
#(
  parameter int MAX = 8,
  parameter int W   = clog2(MAX) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         err
);

  localparam logic [W-1:0] FULL = W'(MAX);

  // Simultaneous inc and dec cancel; a return with nothing outstanding is an error.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt <= FULL;
      err <= 1'b0;
    end else begin
      if (inc && (cnt == FULL)) err <= 1'b1;
      if (dec && !inc) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
      end else if (inc && !dec) begin
        if (cnt != FULL) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_link_tx.sv
// Ring link transmitter: drains the router FIFO onto the link under credit control.
// Latency: 2 cycles from fifo_rd_en to link_valid; 1 flit/cycle sustained.
// Backpressure: no pop when FIFO is empty, credits are zero, or the lane is disabled.
module ring_link_tx
  import ring_link_tx_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS,
  parameter int CREDITS  = 8,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [NUM_BITS-1:0]     fifo_data,
  output logic                    link_valid,
  output logic [NUM_BITS-1:0]     link_data,
  input  logic                    link_credit,
  output logic [clog2(CREDITS):0] credit_cnt,
  output logic                    busy,
  output logic                    credit_err,
  output logic [CNT_W-1:0]        tx_count
);

  localparam int CW = clog2(CREDITS) + 1;

  tx_state_e state;
  logic      pend;

  // A credit is consumed at pop time, so a pop is only issued when one is available.
  assign fifo_rd_en = (state == ST_ACTIVE) && enable && !fifo_empty && (credit_cnt != '0);

  ring_credit_counter #(
    .MAX (CREDITS),
    .W   (CW)
  ) u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .dec   (fifo_rd_en),
    .inc   (link_credit),
    .cnt   (credit_cnt),
    .err   (credit_err)
  );

  // Two-stage launch: pend marks FIFO read data valid, then it is registered onto the link.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pend       <= 1'b0;
      link_valid <= 1'b0;
      link_data  <= '0;
      tx_count   <= '0;
    end else begin
      pend       <= fifo_rd_en;
      link_valid <= pend;
      if (pend) begin
        link_data <= fifo_data;
        tx_count  <= tx_count + CNT_W'(1);
      end
    end
  end

  // Lane control: quiesce stops popping immediately, then waits for the last pending flit.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_ACTIVE;
            busy  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!enable) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (enable) begin
            state <= ST_ACTIVE;
          end else if (!pend) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_link_tx.sv
// Bench for ring_link_tx: env 0 uses CREDITS=8, env 1 uses CREDITS=2.
// Each env has a queue-based FIFO, a credit/lane reference model and a flit scoreboard.
// A monitor compares every link cycle against the expected-flit queue and model state.
module tb_ring_link_tx;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      en, fe, lc, rd, lv, bz, ce;
  logic [1:0][7:0] fd, ld;
  logic [1:0][15:0] tc;
  logic [3:0]      cc0;
  logic [1:0]      cc1;
  logic [3:0]      cc [2];

  logic [7:0] fq [2][$];
  exp_t       xq [2][$];
  int         mcred [2];
  bit         merr [2];
  int         mmode [2];
  bit         lastpop [2];
  int         mtx [2];
  bit         last_rd [2];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  assign cc[0] = cc0;
  assign cc[1] = {2'b00, cc1};

  ring_link_tx #(.NUM_BITS(8), .CREDITS(8), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .fifo_empty(fe[0]), .fifo_rd_en(rd[0]),
    .fifo_data(fd[0]), .link_valid(lv[0]), .link_data(ld[0]), .link_credit(lc[0]),
    .credit_cnt(cc0), .busy(bz[0]), .credit_err(ce[0]), .tx_count(tc[0])
  );

  ring_link_tx #(.NUM_BITS(8), .CREDITS(2), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .fifo_empty(fe[1]), .fifo_rd_en(rd[1]),
    .fifo_data(fd[1]), .link_valid(lv[1]), .link_data(ld[1]), .link_credit(lc[1]),
    .credit_cnt(cc1), .busy(bz[1]), .credit_err(ce[1]), .tx_count(tc[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cr(input int e);
    return (e == 0) ? 8 : 2;
  endfunction

  task automatic chk(input string nm, input int e, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s env%0d cyc %0d: got %0h want %0h", nm, e, cyc, act, exp);
    end
  endtask

  task automatic push(input int e, input logic [7:0] d);
    fq[e].push_back(d);
    fe[e] = 1'b0;
  endtask

  task automatic model_reset();
    for (int e = 0; e < 2; e++) begin
      xq[e].delete();
      mcred[e]   = cr(e);
      merr[e]    = 1'b0;
      mmode[e]   = 0;
      lastpop[e] = 1'b0;
      mtx[e]     = 0;
    end
  endtask

  // Called just after a falling edge with inputs settled; covers one rising edge.
  task automatic tick();
    bit p;
    #1;
    for (int e = 0; e < 2; e++) begin
      p = (mmode[e] == 1) && en[e] && !fe[e] && (mcred[e] != 0);
      chk("pop_rule", e, rd[e], p);
      last_rd[e] = rd[e];
      if (p) xq[e].push_back('{d: fq[e][0], due: cyc + 2});
      if (lc[e] && mcred[e] == cr(e)) merr[e] = 1'b1;
      if (p && !lc[e]) mcred[e]--;
      else if (lc[e] && !p && mcred[e] < cr(e)) mcred[e]++;
      case (mmode[e])
        0: if (en[e]) mmode[e] = 1;
        1: if (!en[e]) mmode[e] = 2;
        default: begin
          if (en[e]) mmode[e] = 1;
          else if (!lastpop[e]) mmode[e] = 0;
        end
      endcase
      lastpop[e] = p;
    end
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      if (last_rd[e] && fq[e].size() != 0) fd[e] = fq[e].pop_front();
      fe[e] = (fq[e].size() == 0);
    end
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b1;
    #1;
    for (int e = 0; e < 2; e++) begin
      chk("rst_link_valid", e, lv[e], 1'b0);
      chk("rst_credit_cnt", e, cc[e], cr(e));
      chk("rst_tx_count", e, tc[e], 0);
      chk("rst_busy", e, bz[e], 1'b0);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  // Monitor: every cycle out of reset, the link must carry exactly the flit that is due.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n !== 1'b0) continue;
      for (int e = 0; e < 2; e++) begin
        if (xq[e].size() != 0 && xq[e][0].due == cyc) begin
          x = xq[e].pop_front();
          mtx[e]++;
          chk("flit_valid", e, lv[e], 1'b1);
          chk("flit_data", e, ld[e], x.d);
        end else begin
          chk("no_flit", e, lv[e], 1'b0);
        end
        chk("credit_cnt", e, cc[e], mcred[e]);
        chk("busy", e, bz[e], (mmode[e] != 0));
        chk("credit_err", e, ce[e], merr[e]);
        chk("tx_count", e, tc[e], mtx[e] & 32'hFFFF);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    en = '0; fe = '1; lc = '0; fd = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    for (int e = 0; e < 2; e++) begin
      chk("reset_rd_en", e, rd[e], 1'b0);
      chk("reset_link_valid", e, lv[e], 1'b0);
      chk("reset_link_data", e, ld[e], 0);
      chk("reset_credit_cnt", e, cc[e], cr(e));
      chk("reset_busy", e, bz[e], 1'b0);
      chk("reset_credit_err", e, ce[e], 1'b0);
      chk("reset_tx_count", e, tc[e], 0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    tick();

    // Three flits on env 0; four flits against two credits on env 1.
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    for (int i = 0; i < 4; i++) push(1, 8'hA0 + 8'(i));
    en = 2'b11;
    repeat (8) tick();
    chk("t1_credit_cnt", 0, cc[0], 5);
    chk("t1_tx_count", 0, tc[0], 3);
    chk("t2_credit_cnt", 1, cc[1], 0);
    chk("t2_fifo_left", 1, fq[1].size(), 2);
    chk("t2_tx_count", 1, tc[1], 2);
    chk("t2_rd_en_held", 1, rd[1], 1'b0);
    lc[1] = 1'b1;
    tick();
    lc[1] = 1'b0;
    repeat (4) tick();
    chk("t2_after_credit_tx", 1, tc[1], 3);
    chk("t2_after_credit_fifo", 1, fq[1].size(), 1);
    chk("t2_after_credit_cnt", 1, cc[1], 0);
    en[1] = 1'b0;

    // Pop and credit return in the same cycle at credit_cnt = 3.
    push(0, 8'h3C); push(0, 8'hC3);
    repeat (3) tick();
    chk("t3_pre_cnt", 0, cc[0], 3);
    push(0, 8'h44);
    lc[0] = 1'b1;
    tick();
    lc[0] = 1'b0;
    chk("t3_popped", 0, last_rd[0], 1'b1);
    chk("t3_credit_cnt", 0, cc[0], 3);
    repeat (3) tick();

    // Return all credits, then one too many.
    for (int i = 0; i < 16 && mcred[0] < 8; i++) begin
      lc[0] = 1'b1;
      tick();
    end
    lc[0] = 1'b0;
    chk("t4_full", 0, cc[0], 8);
    chk("t4_err_clear", 0, ce[0], 1'b0);
    lc[0] = 1'b1;
    tick();
    lc[0] = 1'b0;
    chk("t4_cnt_sat", 0, cc[0], 8);
    chk("t4_err_set", 0, ce[0], 1'b1);
    repeat (3) tick();
    chk("t4_err_sticky", 0, ce[0], 1'b1);

    // Quiesce the cycle after a pop with five entries still queued.
    for (int i = 0; i < 6; i++) push(0, 8'h50 + 8'(i));
    tick();
    chk("t5_popped", 0, last_rd[0], 1'b1);
    en[0] = 1'b0;
    repeat (6) tick();
    chk("t5_fifo_kept", 0, fq[0].size(), 5);
    chk("t5_idle", 0, bz[0], 1'b0);

    // Reset with two flits in flight.
    en[0] = 1'b1;
    repeat (3) tick();
    chk("t6_in_flight", 0, lv[0], 1'b1);
    en[0] = 1'b0;
    do_reset();
    repeat (5) tick();
    chk("t6_fifo_after", 0, fq[0].size(), 3);
    chk("t6_tx_after", 0, tc[0], 0);

    // Randomised traffic, lane toggling and credit returns.
    for (int i = 0; i < 800; i++) begin
      for (int e = 0; e < 2; e++) begin
        if (en[e]) begin
          if ($urandom_range(0, 39) == 0) en[e] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          en[e] = 1'b1;
        end
        if (fq[e].size() < 12 && $urandom_range(0, 1) == 1) push(e, 8'($urandom));
        lc[e] = (mcred[e] < cr(e)) && ($urandom_range(0, 2) == 0);
      end
      tick();
    end

    // Quiesce both lanes and settle all credits.
    en = 2'b00;
    for (int i = 0; i < 20; i++) begin
      for (int e = 0; e < 2; e++) lc[e] = (mcred[e] < cr(e));
      tick();
    end
    lc = 2'b00;
    repeat (2) tick();
    for (int e = 0; e < 2; e++) begin
      chk("end_no_pending", e, xq[e].size(), 0);
      chk("end_idle", e, bz[e], 1'b0);
      chk("end_credits", e, cc[e], cr(e));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ring_link_tx.md
Name: ring_link_tx

Overview:
- Ring-router output-port transmitter: the drain side of a router input/output FIFO.
- Pops flits from the FIFO using its rd_en/empty/registered-data read interface and drives them onto a ring link.
- Uses credit-based flow control against the downstream router's input buffer.
- A lane enable allows the port to be quiesced cleanly: stop popping, flush in-flight flits, report idle.

Parameters:
- NUM_BITS, 8, flit width; must match the FIFO's NUM_BITS.
- CREDITS, 8, downstream buffer depth = initial credit count; power of 2 not required, ≥1.
- CNT_W, 16, width of the transmitted-flit counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high (asserted = 1 despite the name)
- enable  in  1  1 = transmit allowed; 0 = request quiesce
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO pop request (combinational)
- fifo_data  in  NUM_BITS  FIFO registered output, valid the cycle after a pop
- link_valid  out  1  flit present on link this cycle (registered)
- link_data  out  NUM_BITS  flit payload (registered)
- link_credit  in  1  one-cycle pulse = downstream freed one slot
- credit_cnt  out  clog2(CREDITS)+1  credits currently available
- busy  out  1  state != IDLE
- credit_err  out  1  sticky: credit returned while credit_cnt == CREDITS
- tx_count  out  CNT_W  flits sent, wraps modulo 2^CNT_W

Behaviour:
- Reset values: fifo_rd_en = 0, link_valid = 0, link_data = 0, credit_cnt = CREDITS, busy = 0, credit_err = 0, tx_count = 0, state = IDLE, pend = 0.
- Pop rule: fifo_rd_en = (state == ACTIVE) && enable && !fifo_empty && (credit_cnt != 0).
  - Never pops while empty.
  - The credit is reserved at pop time.
- Pipeline:
  - cycle t: pop issued.
  - t+1: pend = 1 and fifo_data is valid.
  - t+2: link_valid = 1 with link_data = the fifo_data captured at t+1, and tx_count increments.
  - Latency is pop to link_valid = 2 cycles. Sustained throughput is 1 flit/cycle.
  - Bubbles appear only when the FIFO is empty or credits are exhausted.
- link_data holds its last value when link_valid = 0.
- Credit counter:
  - pop only: −1.
  - link_credit only: +1.
  - Both in the same cycle: unchanged.
  - link_credit at CREDITS: ignored, count stays at CREDITS, credit_err set to 1 until reset.
  - Never underflows; the pop rule guarantees this.
- FIFO empty timing: the FIFO updates empty on the same edge as the pop, so back-to-back pops with 1 entry left cannot double-pop.
- FSM:
  - IDLE -> ACTIVE when enable = 1.
  - ACTIVE -> DRAIN when enable = 0. No new pops from that cycle on, because the pop rule is gated by enable.
  - DRAIN -> IDLE when pend == 0 and no flit is launching this cycle, i.e. all in-flight flits have been sent.
  - DRAIN -> ACTIVE if enable returns to 1 before drained.
  - Credits keep being accepted in every state.
- busy = 1 in ACTIVE and DRAIN.
- Reset mid-operation: in-flight flits are discarded and credits are restored to CREDITS. The downstream router is reset by the same rst_n.

Decomposition:
- Shared router package/include: clog2 function, FSM state encodings (IDLE = 0, ACTIVE = 1, DRAIN = 2), default NUM_BITS.
- One natural sub-module, ring_credit_counter: up/down saturating counter with an overflow-error flag, reusable by the receive side for credit return.

Test Plan:
- Reset, enable = 1, FIFO holding 0x11, 0x22, 0x33, link_credit = 0:
  - link_valid high on 3 consecutive cycles with 0x11, 0x22, 0x33.
  - First flit appears 2 cycles after the first fifo_rd_en.
  - credit_cnt 8 -> 5, tx_count = 3.
- CREDITS = 2, FIFO holding 4 flits, no credit returns:
  - exactly 2 pops and 2 flits sent, credit_cnt = 0, fifo_rd_en stays 0.
  - One link_credit pulse then gives exactly one more flit, 2 cycles after the pop.
- Pop and link_credit in the same cycle with credit_cnt = 3: credit_cnt stays 3.
- link_credit pulse with credit_cnt = 8 (CREDITS): credit_cnt stays 8, credit_err = 1 and remains 1.
- Deassert enable the cycle after a pop, FIFO still holding 5 entries:
  - that one flit is still sent, no further pops.
  - busy falls the cycle after the last link_valid, FIFO keeps 5.
- Assert rst_n while 2 flits are in flight:
  - link_valid = 0 immediately (asynchronous), credit_cnt = 8, tx_count = 0, state IDLE.
  - No stale flit is emitted after reset release.
